// File: rtl/iir_out_quantizer_pkg.sv
// Shared constants and the round-half-up / saturate quantizer used by the IIR output stage.
// quantize() is sized by the package widths, so instances must keep IN_W/OUT_W at these defaults.
package iir_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 8;
    localparam int DEF_SHIFT = 4;

    localparam logic signed [DEF_IN_W:0] Q_MAX = (DEF_IN_W+1)'(2**(DEF_OUT_W-1) - 1);
    localparam logic signed [DEF_IN_W:0] Q_MIN = (DEF_IN_W+1)'(-(2**(DEF_OUT_W-1)));

    // Returns {sat, q}; the extra bit keeps the rounding add from overflowing.
    function automatic logic [DEF_OUT_W:0] quantize(input logic signed [DEF_IN_W-1:0] din,
                                                    input int shift);
        logic signed [DEF_IN_W:0] t;
        logic signed [DEF_IN_W:0] s;
        t = {din[DEF_IN_W-1], din};
        if (shift > 0) begin
            t = t + ((DEF_IN_W+1)'(1) <<< (shift - 1));
        end
        s = t >>> shift;
        if (s > Q_MAX) begin
            return {1'b1, Q_MAX[DEF_OUT_W-1:0]};
        end else if (s < Q_MIN) begin
            return {1'b1, Q_MIN[DEF_OUT_W-1:0]};
        end
        return {1'b0, s[DEF_OUT_W-1:0]};
    endfunction

endpackage

// File: rtl/iir_out_quantizer_if.sv
// Sample stream and diagnostics bundle between the IIR output stage and its neighbours.
interface iir_out_quantizer_if
    import iir_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic        [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic        [LVL_W-1:0] fifo_level;
    logic        [7:0]       sat_cnt;
    logic        [7:0]       drop_cnt;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, fifo_level, sat_cnt, drop_cnt
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, fifo_level, sat_cnt, drop_cnt
    );

endinterface

// File: rtl/iir_out_quantizer_sample_fifo.sv
// First-word fall-through FIFO; a push while full is taken only alongside a pop.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    // Force zero when empty so the head word never shows stale storage after reset.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; validity is governed entirely by level_q.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/iir_out_quantizer.sv
// IIR output stage: round/saturate to OUT_W, stage register, FWFT FIFO and diagnostic counters.
module iir_out_quantizer
    import iir_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    iir_out_quantizer_if.slave   bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [OUT_W:0]     qs;
    logic               stg_valid_q, stg_valid_d;
    logic [OUT_W-1:0]   stg_data_q, stg_data_d;
    logic               stg_sat_q, stg_sat_d;
    logic [7:0]         sat_cnt_q, sat_cnt_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [OUT_W-1:0]   fifo_dout;
    logic [LVL_W-1:0]   fifo_level;

    assign qs = quantize(bus.in_data, SHIFT);

    always_comb begin
        stg_valid_d = bus.in_valid;
        stg_data_d  = stg_data_q;
        stg_sat_d   = stg_sat_q;
        if (bus.in_valid) begin
            stg_data_d = qs[OUT_W-1:0];
            stg_sat_d  = qs[OUT_W];
        end

        fifo_push = stg_valid_q;
        fifo_pop  = !fifo_empty && bus.out_ready;

        // Saturation is counted whether or not the sample survives the FIFO.
        sat_cnt_d = sat_cnt_q;
        if (stg_valid_q && stg_sat_q && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end

        drop_cnt_d = drop_cnt_q;
        if (stg_valid_q && fifo_full && !fifo_pop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_data_q  <= '0;
            stg_sat_q   <= 1'b0;
            sat_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_data_q  <= stg_data_d;
            stg_sat_q   <= stg_sat_d;
            sat_cnt_q   <= sat_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (stg_data_q),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_data   = fifo_dout;
    assign bus.out_valid  = !fifo_empty;
    assign bus.fifo_level = fifo_level;
    assign bus.sat_cnt    = sat_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_iir_out_quantizer.sv
// Self-checking bench for iir_out_quantizer: directed plan steps plus randomized traffic
// compared against a queue-based reference model.
module tb_iir_out_quantizer;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;
    localparam int QMAX  = 2**(OUT_W-1) - 1;
    localparam int QMIN  = -(2**(OUT_W-1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iir_out_quantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    iir_out_quantizer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int exp_q[$];
    int m_sat;
    int m_drop;
    bit m_stg_v;
    int m_stg_q;
    bit m_stg_sat;

    function automatic int ref_quant(input int x, output bit sat);
        int t;
        t = x;
        if (SHIFT > 0) t = x + (1 << (SHIFT - 1));
        t = t >>> SHIFT;
        sat = 1'b0;
        if (t > QMAX) begin sat = 1'b1; t = QMAX; end
        if (t < QMIN) begin sat = 1'b1; t = QMIN; end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_sat = 0;
        m_drop = 0;
        m_stg_v = 1'b0;
        m_stg_q = 0;
        m_stg_sat = 1'b0;
    endtask

    task automatic model_edge(input bit iv, input int d, input bit rdy);
        bit pop;
        bit push_ok;
        pop = rdy && (exp_q.size() > 0);
        push_ok = 1'b0;
        if (m_stg_v) begin
            if (m_stg_sat && m_sat < 255) m_sat++;
            if (exp_q.size() < DEPTH || pop) push_ok = 1'b1;
            else if (m_drop < 255) m_drop++;
        end
        if (pop) $display("pop data=%0d level_before=%0d", exp_q.pop_front(), exp_q.size() + 1);
        if (push_ok) exp_q.push_back(m_stg_q);
        m_stg_v = iv;
        if (iv) m_stg_q = ref_quant(d, m_stg_sat);
    endtask

    task automatic check_outputs();
        logic [7:0] e8;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            e8 = 8'(exp_q[0]);
            chk("out_data", 32'(bus.out_data), 32'(e8));
        end
        chk("fifo_level", 32'(bus.fifo_level), 32'(exp_q.size()));
        chk("sat_cnt", 32'(bus.sat_cnt), 32'(m_sat));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic cycle(input bit iv, input int d, input bit rdy);
        bus.in_valid  = iv;
        bus.in_data   = IN_W'(d);
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(iv, d, rdy);
        #1;
        check_outputs();
    endtask

    function automatic int rand_full();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    function automatic int rand_small();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
        chk({tag, "_sat"}, 32'(bus.sat_cnt), 32'd0);
        chk({tag, "_drop"}, 32'(bus.drop_cnt), 32'd0);
    endtask

    initial begin
        int drop_before;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset then idle with out_ready high
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 0, 1'b1);
            check_all_zero("idle");
        end

        // Rounding, each result visible two edges after its in_valid
        cycle(1'b1, 24, 1'b1);
        chk("round_latency", 32'(bus.out_valid), 32'd0);
        cycle(1'b1, -24, 1'b1);
        chk("round_24", 32'(bus.out_data), 32'h02);
        cycle(1'b1, 100, 1'b1);
        chk("round_m24", 32'(bus.out_data), 32'hFF);
        cycle(1'b1, -36, 1'b1);
        chk("round_100", 32'(bus.out_data), 32'h06);
        cycle(1'b0, 0, 1'b1);
        chk("round_m36", 32'(bus.out_data), 32'hFE);
        cycle(1'b0, 0, 1'b1);
        chk("round_sat0", 32'(bus.sat_cnt), 32'd0);

        // Saturation at both rails and just past the positive rail
        cycle(1'b1, 32767, 1'b1);
        cycle(1'b1, -32768, 1'b1);
        chk("sat_7fff", 32'(bus.out_data), 32'h7F);
        cycle(1'b1, 2040, 1'b1);
        chk("sat_8000", 32'(bus.out_data), 32'h80);
        cycle(1'b0, 0, 1'b1);
        chk("sat_2040", 32'(bus.out_data), 32'h7F);
        chk("sat_cnt3", 32'(bus.sat_cnt), 32'd3);
        cycle(1'b0, 0, 1'b1);

        // Overflow: six samples into a stalled FIFO of four
        for (int i = 1; i <= 6; i++) cycle(1'b1, 16 * i, 1'b0);
        cycle(1'b0, 0, 1'b0);
        chk("ovf_level", 32'(bus.fifo_level), 32'd4);
        chk("ovf_drop", 32'(bus.drop_cnt), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(bus.out_data), 32'(i));
            cycle(1'b0, 0, 1'b1);
        end
        chk("drain_level", 32'(bus.fifo_level), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_small(), 1'b0);
        drop_before = m_drop;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, rand_small(), 1'b1);
            chk("full_pp_level", 32'(bus.fifo_level), 32'd4);
            chk("full_pp_drop", 32'(bus.drop_cnt), 32'(drop_before));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b1);

        // Randomized mixed traffic
        for (int i = 0; i < 1000; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? rand_full() : rand_small(),
                  $urandom_range(0, 2) != 0);
        end

        // Long stall drives drop_cnt into saturation
        for (int i = 0; i < 300; i++) cycle(1'b1, rand_full(), 1'b0);
        chk("drop_cap", 32'(bus.drop_cnt), 32'd255);
        for (int i = 0; i < 300; i++) cycle(1'b1, rand_full(), 1'b1);
        chk("sat_cap", 32'(bus.sat_cnt), 32'd255);

        // Asynchronous reset between edges in the middle of a burst
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_small(), 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 48, 1'b1);
        chk("post_rst_latency", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 0, 1'b1);
        chk("post_rst_data", 32'(bus.out_data), 32'h03);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_sat", 32'(bus.sat_cnt), 32'd0);
        chk("post_rst_drop", 32'(bus.drop_cnt), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
